// File: rtl/lvds_rx_pkg.sv
// Shared definitions for the LVDS receive word aligner.
//   rx_state_t      : aligner FSM state, 2-bit code exported on o_state
//   W_DEF           : default deserialized word width
//   TRAIN_WORD_DEF  : default training word sent by the far-end transmitter
//   next_slip()     : bit offset after one slip, wrapping at w-1
package lvds_rx_pkg;

   localparam int W_DEF = 10;
   localparam logic [9:0] TRAIN_WORD_DEF = 10'b1010101001;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      WAIT   = 2'd1,
      VERIFY = 2'd2,
      LOCKED = 2'd3
   } rx_state_t;

   function automatic logic [3:0] next_slip(input logic [3:0] pos, input int unsigned w);
      return (pos == 4'(w - 1)) ? 4'd0 : pos + 4'd1;
   endfunction

endpackage

// File: rtl/lvds_bit_window.sv
// Combinational bit-offset window over two consecutive deserializer words.
//   rx_word   in  W  current word (upper half of the window)
//   prev_word in  W  previous valid word (lower half of the window)
//   slip_pos  in  4  bit offset into the window, 0..W-1
//   aligned   out W  window bits [slip_pos +: W]
module lvds_bit_window
   import lvds_rx_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [W-1:0] rx_word,
   input  logic [W-1:0] prev_word,
   input  logic [3:0]   slip_pos,
   output logic [W-1:0] aligned
);

   localparam int IDX_W = $clog2(2 * W);

   logic [2*W-1:0]   cat;
   logic [IDX_W-1:0] idx;

   assign cat     = {rx_word, prev_word};
   assign idx     = IDX_W'(slip_pos);
   assign aligned = cat[idx +: W];

endmodule

// File: rtl/lvds_rx_word_aligner.sv
// LVDS receive word aligner: bit-slips the deserializer output until the
// training word is seen LOCK_CNT times in a row, then forwards aligned words,
// counts word errors and re-hunts after UNLOCK_CNT consecutive misses.
// All state advances only on cycles with i_rx_valid.
//   i_clk_serdes in  1      parallel-word clock
//   i_rstn       in  1      asynchronous active-low reset
//   i_rx_word    in  W      deserializer word
//   i_rx_valid   in  1      i_rx_word qualifier
//   i_clear_err  in  1      zeroes o_err_cnt (a coincident locked miss leaves 1)
//   o_word       out W      aligned word, 1 cycle after each valid word
//   o_word_valid out 1      pulse after each valid word evaluated in LOCKED
//   o_locked     out 1      alignment locked
//   o_slip_pos   out 4      current bit offset
//   o_err_cnt    out ERR_W  saturating mismatch count while locked
//   o_state      out 2      FSM state code
//
// state  | meaning
// HUNT   | compare aligned word against TRAIN_WORD, slip on a miss
// WAIT   | discard SLIP_WAIT valid words after a slip
// VERIFY | count consecutive matches up to LOCK_CNT
// LOCKED | forward words, count misses, re-hunt after UNLOCK_CNT in a row
module lvds_rx_word_aligner
   import lvds_rx_pkg::*;
#(
   parameter int          W          = W_DEF,
   parameter logic [W-1:0] TRAIN_WORD = TRAIN_WORD_DEF,
   parameter int          LOCK_CNT   = 8,
   parameter int          UNLOCK_CNT = 4,
   parameter int          SLIP_WAIT  = 2,
   parameter int          ERR_W      = 16
) (
   input  logic             i_clk_serdes,
   input  logic             i_rstn,
   input  logic [W-1:0]     i_rx_word,
   input  logic             i_rx_valid,
   input  logic             i_clear_err,
   output logic [W-1:0]     o_word,
   output logic             o_word_valid,
   output logic             o_locked,
   output logic [3:0]       o_slip_pos,
   output logic [ERR_W-1:0] o_err_cnt,
   output logic [1:0]       o_state
);

   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);
   localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);

   rx_state_t          state, state_next;
   logic [W-1:0]       prev_word;
   logic [W-1:0]       aligned;
   logic               is_match;
   logic [3:0]         slip_pos, slip_next;
   logic [WAIT_W-1:0]  wait_cnt, wait_next;
   logic [MATCH_W-1:0] match_cnt, match_next;
   logic [MISS_W-1:0]  miss_cnt, miss_next;
   logic               err_hit;
   logic               word_valid_next;
   logic               locked_next;
   logic [ERR_W-1:0]   err_next;

   lvds_bit_window #(.W(W)) u_window (
      .rx_word   (i_rx_word),
      .prev_word (prev_word),
      .slip_pos  (slip_pos),
      .aligned   (aligned)
   );

   assign is_match = (aligned == TRAIN_WORD);

   always_ff @(posedge i_clk_serdes or negedge i_rstn) begin
      if (!i_rstn) begin
         state <= HUNT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      slip_next  = slip_pos;
      wait_next  = wait_cnt;
      match_next = match_cnt;
      miss_next  = miss_cnt;
      err_hit    = 1'b0;
      if (i_rx_valid) begin
         case (state)
            HUNT: begin
               if (is_match) begin
                  match_next = MATCH_W'(1);
                  miss_next  = '0;
                  state_next = (LOCK_CNT == 1) ? LOCKED : VERIFY;
               end else begin
                  slip_next  = next_slip(slip_pos, W);
                  wait_next  = WAIT_W'(SLIP_WAIT);
                  state_next = WAIT;
               end
            end
            WAIT: begin
               wait_next = wait_cnt - WAIT_W'(1);
               if (wait_cnt == WAIT_W'(1)) begin
                  state_next = HUNT;
               end
            end
            VERIFY: begin
               if (is_match) begin
                  match_next = match_cnt + MATCH_W'(1);
                  if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                     miss_next  = '0;
                     state_next = LOCKED;
                  end
               end else begin
                  match_next = '0;
                  slip_next  = next_slip(slip_pos, W);
                  wait_next  = WAIT_W'(SLIP_WAIT);
                  state_next = WAIT;
               end
            end
            LOCKED: begin
               if (is_match) begin
                  miss_next = '0;
               end else begin
                  err_hit   = 1'b1;
                  miss_next = miss_cnt + MISS_W'(1);
                  // Lock loss keeps the current offset so the re-hunt starts where it was.
                  if (miss_cnt == MISS_W'(UNLOCK_CNT - 1)) begin
                     miss_next  = '0;
                     match_next = '0;
                     state_next = HUNT;
                  end
               end
            end
            default: state_next = HUNT;
         endcase
      end
   end

   always_comb begin
      word_valid_next = i_rx_valid && (state == LOCKED);
      locked_next     = (state_next == LOCKED);
      err_next        = o_err_cnt;
      if (i_clear_err) begin
         err_next = ERR_W'(err_hit);
      end else if (err_hit && (o_err_cnt != '1)) begin
         err_next = o_err_cnt + ERR_W'(1);
      end
   end

   always_ff @(posedge i_clk_serdes or negedge i_rstn) begin
      if (!i_rstn) begin
         prev_word    <= '0;
         slip_pos     <= '0;
         wait_cnt     <= '0;
         match_cnt    <= '0;
         miss_cnt     <= '0;
         o_word       <= '0;
         o_word_valid <= 1'b0;
         o_locked     <= 1'b0;
         o_err_cnt    <= '0;
      end else begin
         slip_pos     <= slip_next;
         wait_cnt     <= wait_next;
         match_cnt    <= match_next;
         miss_cnt     <= miss_next;
         o_word_valid <= word_valid_next;
         o_locked     <= locked_next;
         o_err_cnt    <= err_next;
         if (i_rx_valid) begin
            prev_word <= i_rx_word;
            o_word    <= aligned;
         end
      end
   end

   assign o_slip_pos = slip_pos;
   assign o_state    = state;

endmodule
